pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register; generic successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a payload bus and a separately treated control bus between stages with valid/ready flow control, synchronous flush, and bubble insertion.
- Control bits are squashed to a safe value on flush and reset; payload is not.
- Includes a stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/pipe_stall_counter.sv | 21 ++
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: per-stage widths,
// the EX control bundle, safe (squashed) control constants and skid FSM states.
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [3:0] alu_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       lu_op;
  } ex_ctrl_t;

  localparam int EX_CTRL_W = $bits(ex_ctrl_t);

  // Per-stage payload and control widths.
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = EX_CTRL_W;
  localparam int EXMEM_DATA_W = 64;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 3;

  // Safe control values: no register write, no memory access.
  localparam ex_ctrl_t                EX_CTRL_SAFE    = '0;
  localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_SAFE  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_SAFE  = EX_CTRL_SAFE;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_SAFE = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_SAFE = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter used for per-stage stall statistics.
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && (count != CNT_MAX))
      count <= count + CNT_ONE;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with squashable control and stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               DATA_W    = 64,
  parameter int               CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] CTRL_SAFE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic in_xfer;
  logic out_xfer;
  logic stall;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign stall    = out_valid && !out_ready && !flush;

  pipe_stall_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );

`ifdef PIPE_STAGE_SKID_EN

  skid_state_e       state;
  skid_state_e       state_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) state_nxt = ST_MAIN;
        ST_MAIN: begin
          if (in_xfer && !out_xfer)      state_nxt = ST_SKID;
          else if (out_xfer && !in_xfer) state_nxt = ST_EMPTY;
        end
        ST_SKID:  if (out_xfer) state_nxt = ST_MAIN;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready decodes state only; out_ready never reaches it.
  always_comb begin
    in_ready  = (state != ST_SKID) && !flush && !reset;
    out_valid = (state != ST_EMPTY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_ctrl  <= CTRL_SAFE;
      skid_data <= '0;
      skid_ctrl <= CTRL_SAFE;
    end else if (flush) begin
      out_ctrl  <= CTRL_SAFE;
      skid_ctrl <= CTRL_SAFE;
    end else if ((state == ST_SKID) && out_xfer) begin
      out_data  <= skid_data;
      out_ctrl  <= skid_ctrl;
      skid_ctrl <= CTRL_SAFE;
    end else if (in_xfer && ((state == ST_EMPTY) || out_xfer)) begin
      out_data <= in_data;
      out_ctrl <= in_ctrl;
    end else if (in_xfer) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end else if (out_xfer) begin
      out_ctrl <= CTRL_SAFE;
    end
  end

`else

  assign in_ready = (!out_valid || out_ready) && !flush && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= CTRL_SAFE;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= CTRL_SAFE;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_ctrl  <= in_ctrl;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
      out_ctrl  <= CTRL_SAFE;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a
// queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam logic [CW-1:0] SAFE = 16'h0A50;
  localparam int CMAX = 15;
`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_SAFE(SAFE), .CNT_W(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  item_t         q[$];
  logic [DW-1:0] m_data = '0;
  int            m_cnt = 0;

  function automatic logic m_in_ready();
    return !reset && !flush &&
           ((q.size() < DEPTH) || (DEPTH == 1 && out_ready));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of at most DEPTH items; payload shows the last head seen.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_data = '0;
      m_cnt  = 0;
    end else begin
      bit inx, outx;
      if (q.size() > 0 && !out_ready && !flush && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        inx  = in_valid && m_in_ready();
        outx = (q.size() > 0) && out_ready;
        if (outx) void'(q.pop_front());
        if (inx) q.push_back({in_data, in_ctrl});
      end
      if (q.size() > 0) m_data = q[0].d;
    end
  end

  always @(negedge clk) begin
    check("cmp_out_valid", out_valid, q.size() > 0);
    check("cmp_out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : SAFE);
    check("cmp_out_data", out_data, m_data);
    check("cmp_stall_cnt", stall_cnt, m_cnt);
    check("cmp_in_ready", in_ready, m_in_ready());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_ctrl, SAFE);
    check("rst_cnt", stall_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    #13 reset = 1'b0;
    step();

    // Streaming 1..8 at full throughput.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      in_ctrl = 16'h0100 + i[15:0];
      step();
      check("stream_data", out_data, i);
      check("stream_valid", out_valid, 1);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("bubble_valid", out_valid, 0);
    check("bubble_ctrl", out_ctrl, SAFE);

    // Stall with a pending second item.
    in_valid  = 1'b1;
    in_data   = 64'hA5;
    in_ctrl   = 16'h1234;
    out_ready = 1'b0;
    step();
    check("load_data", out_data, 64'hA5);
    in_data = 64'hB6;
    repeat (5) step();
    check("stall_data", out_data, 64'hA5);
    check("stall_cnt", stall_cnt, 5);
    check("stall_in_ready", in_ready, 0);
    repeat (15) step();
    check("sat_cnt", stall_cnt, 15);

    // Flush with pending input.
    in_data = 64'hC7;
    flush   = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, SAFE);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_no_leak", out_valid, 0);
    check("flush_keeps_cnt", stall_cnt, 15);

    // Asynchronous reset mid-stream.
    in_valid  = 1'b1;
    in_data   = 64'hD8;
    in_ctrl   = 16'hFFFF;
    out_ready = 1'b0;
    step();
    check("pre_rst_ctrl", out_ctrl, 16'hFFFF);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ctrl", out_ctrl, SAFE);
    check("rst_mid_cnt", stall_cnt, 0);
    check("rst_mid_data", out_data, 0);
    #3 reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'hE9;
    in_ctrl  = 16'h0005;
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 64'hE9);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = {$urandom, $urandom};
      in_ctrl   = $urandom_range(0, 16'hFFFF);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("drain_valid", out_valid, 0);

`ifdef PIPE_STAGE_SKID_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    step();
    in_data = 64'h22;
    step();
    in_valid = 1'b0;
    check("skid_full_in_ready", in_ready, 0);
    check("skid_first", out_data, 64'h11);
    out_ready = 1'b1;
    step();
    check("skid_second", out_data, 64'h22);
    check("skid_main_in_ready", in_ready, 1);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
